// File: rtl/alu_unit.sv
// alu_unit: registered binary32 add/sub/mul/div/compare slice.
// Divider is built only when FPALU_DIV_EN is defined.
module alu_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] z,
    output logic        gr,
    output logic        ls,
    output logic        eq
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [31:0] z_q, z_d;
    logic        gr_q, gr_d;
    logic        ls_q, ls_d;
    logic        eq_q, eq_d;

    function automatic logic is_zero(input logic [31:0] x);
        return x[30:23] == 8'h00;
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Significand with hidden bit; subnormals flush to zero.
    function automatic logic [23:0] sig(input logic [31:0] x);
        return is_zero(x) ? 24'd0 : {1'b1, x[22:0]};
    endfunction

    // Magnitude key for ordering; subnormals flush to zero.
    function automatic logic [30:0] mag(input logic [31:0] x);
        return is_zero(x) ? 31'd0 : x[30:0];
    endfunction

    // Assemble a normalised result, saturating to inf or flushing to +0.
    function automatic logic [31:0] pack(
        input logic               s,
        input logic signed [10:0] e,
        input logic [23:0]        m
    );
        if (e >= 11'sd255)
            return {s, 8'hFF, 23'd0};
        else if (e <= 11'sd0)
            return 32'd0;
        else
            return {s, e[7:0], m[22:0]};
    endfunction

    // Add with caller-supplied operand signs (sub flips y's sign first).
    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0]        l, s;
        logic [7:0]         d;
        logic [26:0]        ext, sh, nrm;
        logic [27:0]        sum;
        logic [4:0]         lz;
        logic signed [10:0] e;
        if (is_nan(x) || is_nan(y))
            return QNAN;
        if (is_inf(x) && is_inf(y))
            return (x[31] != y[31]) ? QNAN : x;
        if (is_inf(x))
            return x;
        if (is_inf(y))
            return y;
        if (mag(x) >= mag(y)) begin
            l = x;
            s = y;
        end else begin
            l = y;
            s = x;
        end
        d   = l[30:23] - (is_zero(s) ? l[30:23] : s[30:23]);
        ext = {sig(s), 3'b000};
        if (d >= 8'd27) begin
            sh    = 27'd0;
            sh[0] = |ext;
        end else begin
            sh    = ext >> d;
            sh[0] = sh[0] | ((sh << d) != ext);
        end
        if (l[31] == s[31])
            sum = {1'b0, sig(l), 3'b000} + {1'b0, sh};
        else
            sum = {1'b0, sig(l), 3'b000} - {1'b0, sh};
        if (sum == 28'd0)
            return 32'd0;
        if (sum[27]) begin
            e = $signed({3'b000, l[30:23]}) + 11'sd1;
            return pack(l[31], e, sum[27:4]);
        end
        lz = 5'd0;
        for (int i = 0; i < 27; i++)
            if (sum[i])
                lz = 5'(26 - i);
        nrm = sum[26:0] << lz;
        e   = $signed({3'b000, l[30:23]}) - $signed({6'b000000, lz});
        return pack(l[31], e, nrm[26:3]);
    endfunction

    // Multiply: 24x24 product, at most one bit of normalisation.
    function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
        logic               s;
        logic [47:0]        p;
        logic signed [10:0] e;
        s = x[31] ^ y[31];
        if (is_nan(x) || is_nan(y))
            return QNAN;
        if ((is_inf(x) && is_zero(y)) || (is_inf(y) && is_zero(x)))
            return QNAN;
        if (is_inf(x) || is_inf(y))
            return {s, 8'hFF, 23'd0};
        if (is_zero(x) || is_zero(y))
            return {s, 31'd0};
        p = sig(x) * sig(y);
        e = $signed({3'b000, x[30:23]}) + $signed({3'b000, y[30:23]}) - 11'sd127;
        if (p[47])
            return pack(s, e + 11'sd1, p[47:24]);
        return pack(s, e, p[46:23]);
    endfunction

`ifdef FPALU_DIV_EN
    // Divide: 26-bit restoring quotient, unrolled combinationally.
    function automatic logic [31:0] fp_div(input logic [31:0] x, input logic [31:0] y);
        logic               s;
        logic [25:0]        q, rem;
        logic signed [10:0] e;
        s = x[31] ^ y[31];
        if (is_nan(x) || is_nan(y))
            return QNAN;
        if ((is_zero(x) && is_zero(y)) || (is_inf(x) && is_inf(y)))
            return QNAN;
        if (is_inf(x) || is_zero(y))
            return {s, 8'hFF, 23'd0};
        if (is_inf(y) || is_zero(x))
            return {s, 31'd0};
        q   = 26'd0;
        rem = {2'b00, sig(x)};
        for (int i = 25; i >= 0; i--) begin
            if (rem >= {2'b00, sig(y)}) begin
                q[i] = 1'b1;
                rem  = rem - {2'b00, sig(y)};
            end
            rem = rem << 1;
        end
        e = $signed({3'b000, x[30:23]}) - $signed({3'b000, y[30:23]}) + 11'sd127;
        if (q[25])
            return pack(s, e, q[25:2]);
        return pack(s, e - 11'sd1, q[24:1]);
    endfunction
`endif

    // Compare: returns {gr, ls, eq}; all clear when unordered.
    function automatic logic [2:0] fp_cmp(input logic [31:0] x, input logic [31:0] y);
        if (is_nan(x) || is_nan(y))
            return 3'b000;
        if (mag(x) == 31'd0 && mag(y) == 31'd0)
            return 3'b001;
        if (x[31] != y[31])
            return x[31] ? 3'b010 : 3'b100;
        if (mag(x) == mag(y))
            return 3'b001;
        return ((mag(x) > mag(y)) ^ x[31]) ? 3'b100 : 3'b010;
    endfunction

    // Select the next result and flags from the opcode.
    always_comb begin
        z_d  = 32'd0;
        gr_d = 1'b0;
        ls_d = 1'b0;
        eq_d = 1'b0;
        case (op)
            3'b000: z_d = fp_add(a, b);
            3'b001: z_d = fp_add(a, {~b[31], b[30:0]});
            3'b010: z_d = fp_mul(a, b);
`ifdef FPALU_DIV_EN
            3'b011: z_d = fp_div(a, b);
`endif
            3'b100: {gr_d, ls_d, eq_d} = fp_cmp(a, b);
            default: z_d = 32'd0;
        endcase
    end

    // Register result and flags; reset wins over the sampled op.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_q  <= 32'd0;
            gr_q <= 1'b0;
            ls_q <= 1'b0;
            eq_q <= 1'b0;
        end else begin
            z_q  <= z_d;
            gr_q <= gr_d;
            ls_q <= ls_d;
            eq_q <= eq_d;
        end
    end

    assign z  = z_q;
    assign gr = gr_q;
    assign ls = ls_q;
    assign eq = eq_q;

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed and randomised checks of alu_unit
// against a real-arithmetic reference model.
module tb_alu_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  op;
    logic [31:0] a, b, z;
    logic        gr, ls, eq;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    alu_unit dut (
        .clk(clk),
        .rst(rst),
        .op(op),
        .a(a),
        .b(b),
        .z(z),
        .gr(gr),
        .ls(ls),
        .eq(eq)
    );

    // binary32 -> real, subnormals flushed
    function automatic real f2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0)
            return x[31] ? -0.0 : 0.0;
        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // real -> binary32, truncating
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        d = $realtobits(r);
        if (d[62:52] == 11'd0)
            return {d[63], 31'd0};
        e = int'(d[62:52]) - 1023 + 127;
        if (e >= 255)
            return {d[63], 8'hFF, 23'd0};
        if (e <= 0)
            return 32'd0;
        return {d[63], 8'(e), d[51:29]};
    endfunction

    function automatic logic [31:0] model_z(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        real r;
        case (o)
            3'd0: begin
                r = f2r(x) + f2r(y);
                return (r == 0.0) ? 32'd0 : r2f(r);
            end
            3'd1: begin
                r = f2r(x) - f2r(y);
                return (r == 0.0) ? 32'd0 : r2f(r);
            end
            3'd2: return r2f(f2r(x) * f2r(y));
`ifdef FPALU_DIV_EN
            3'd3: return r2f(f2r(x) / f2r(y));
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [2:0] model_f(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o != 3'd4)
            return 3'b000;
        return {f2r(x) > f2r(y), f2r(x) < f2r(y), f2r(x) == f2r(y)};
    endfunction

    // small integer times a power of two: exact in all ops used
    function automatic real rnd_real();
        int  n, k;
        real r;
        n = int'($urandom_range(2000, 0)) - 1000;
        k = int'($urandom_range(8, 0)) - 4;
        r = n;
        if (k > 0)
            repeat (k) r = r * 2.0;
        else
            repeat (-k) r = r * 0.5;
        return r;
    endfunction

    task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o;
        a  = x;
        b  = y;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        op  = 3'b000;
        a   = 32'h3F80_0000;
        b   = 32'h3F80_0000;
        @(posedge clk);
        #1;
        total++;
        if (z !== 32'd0 || {gr, ls, eq} !== 3'b000)
            $display("FAIL reset z=%h flags=%b exp z=00000000 flags=000", z, {gr, ls, eq});
        else
            passed++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(3'b110, 32'h4000_0000, 32'h3F80_0000);
            total++;
            if (z !== 32'd0 || {gr, ls, eq} !== 3'b000)
                $display("FAIL nop%0d z=%h flags=%b exp 0", i, z, {gr, ls, eq});
            else
                passed++;
        end
        drive(3'b000, 32'h3F80_0000, 32'h3F80_0000);
        @(negedge clk);
        rst = 1'b1;
        op  = 3'b000;
        @(posedge clk);
        #1;
        total++;
        if (z !== 32'd0)
            $display("FAIL reset_mid z=%h exp=00000000", z);
        else
            passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_addsub();
        drive(3'b000, 32'h3F80_0000, 32'hBF40_0000);
        total++;
        if (z !== 32'h3E80_0000)
            $display("FAIL add_mixed z=%h exp=3e800000", z);
        else
            passed++;
        drive(3'b001, 32'hBF80_0000, 32'hBF40_0000);
        total++;
        if (z !== 32'hBE80_0000)
            $display("FAIL sub_mixed z=%h exp=be800000", z);
        else
            passed++;
        drive(3'b001, 32'h4040_0000, 32'h4040_0000);
        total++;
        if (z !== 32'h0000_0000)
            $display("FAIL sub_zero z=%h exp=00000000", z);
        else
            passed++;
    endtask

    task automatic test_mul();
        drive(3'b010, 32'hC120_0000, 32'h4000_0000);
        total++;
        if (z !== 32'hC1A0_0000 || {gr, ls, eq} !== 3'b000)
            $display("FAIL mul z=%h flags=%b exp z=c1a00000 flags=000", z, {gr, ls, eq});
        else
            passed++;
    endtask

    task automatic test_div();
        logic [31:0] e1, e2, e3;
`ifdef FPALU_DIV_EN
        e1 = 32'h4080_0000;
        e2 = 32'h7F80_0000;
        e3 = 32'h7FC0_0000;
`else
        e1 = 32'd0;
        e2 = 32'd0;
        e3 = 32'd0;
`endif
        drive(3'b011, 32'h40C0_0000, 32'h3FC0_0000);
        total++;
        if (z !== e1)
            $display("FAIL div z=%h exp=%h", z, e1);
        else
            passed++;
        drive(3'b011, 32'h3F80_0000, 32'h0000_0000);
        total++;
        if (z !== e2)
            $display("FAIL div_by_zero z=%h exp=%h", z, e2);
        else
            passed++;
        drive(3'b011, 32'h0000_0000, 32'h0000_0000);
        total++;
        if (z !== e3)
            $display("FAIL div_zero_zero z=%h exp=%h", z, e3);
        else
            passed++;
    endtask

    task automatic test_compare();
        drive(3'b100, 32'h4020_0000, 32'h3FC0_0000);
        total++;
        if ({gr, ls, eq} !== 3'b100 || z !== 32'd0)
            $display("FAIL cmp_gt flags=%b z=%h exp flags=100 z=0", {gr, ls, eq}, z);
        else
            passed++;
        drive(3'b100, 32'h3FC0_0000, 32'h4020_0000);
        total++;
        if ({gr, ls, eq} !== 3'b010)
            $display("FAIL cmp_lt flags=%b exp=010", {gr, ls, eq});
        else
            passed++;
        drive(3'b100, 32'h8000_0000, 32'h0000_0000);
        total++;
        if ({gr, ls, eq} !== 3'b001)
            $display("FAIL cmp_zero flags=%b exp=001", {gr, ls, eq});
        else
            passed++;
        drive(3'b100, 32'h7FC0_0000, 32'h3F80_0000);
        total++;
        if ({gr, ls, eq} !== 3'b000)
            $display("FAIL cmp_nan flags=%b exp=000", {gr, ls, eq});
        else
            passed++;
        drive(3'b100, 32'hFF80_0000, 32'hC120_0000);
        total++;
        if ({gr, ls, eq} !== 3'b010)
            $display("FAIL cmp_neg_inf flags=%b exp=010", {gr, ls, eq});
        else
            passed++;
    endtask

    task automatic test_specials();
        drive(3'b000, 32'h7F80_0000, 32'hFF80_0000);
        total++;
        if (z !== 32'h7FC0_0000)
            $display("FAIL inf_minus_inf z=%h exp=7fc00000", z);
        else
            passed++;
        drive(3'b010, 32'h7F00_0000, 32'h7F00_0000);
        total++;
        if (z !== 32'h7F80_0000)
            $display("FAIL mul_overflow z=%h exp=7f800000", z);
        else
            passed++;
        drive(3'b010, 32'h0000_0000, 32'hFF80_0000);
        total++;
        if (z !== 32'h7FC0_0000)
            $display("FAIL zero_times_inf z=%h exp=7fc00000", z);
        else
            passed++;
        drive(3'b010, 32'h0080_0000, 32'h0080_0000);
        total++;
        if (z !== 32'h0000_0000)
            $display("FAIL mul_underflow z=%h exp=00000000", z);
        else
            passed++;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops [6];
        logic [31:0] xs  [6];
        logic [31:0] ys  [6];
        logic [31:0] prev, want;
        ops = '{3'd0, 3'd2, 3'd4, 3'd1, 3'd7, 3'd0};
        xs  = '{32'h3F80_0000, 32'h4040_0000, 32'h4000_0000,
                32'h4120_0000, 32'h4000_0000, 32'hC000_0000};
        ys  = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000};
        prev = z;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            op = ops[i];
            a  = xs[i];
            b  = ys[i];
            #1;
            total++;
            if (z !== prev)
                $display("FAIL b2b_hold%0d z=%h exp=%h", i, z, prev);
            else
                passed++;
            @(posedge clk);
            #1;
            want = model_z(ops[i], xs[i], ys[i]);
            total++;
            if (z !== want || {gr, ls, eq} !== model_f(ops[i], xs[i], ys[i]))
                $display("FAIL b2b%0d z=%h flags=%b exp z=%h flags=%b", i, z, {gr, ls, eq},
                         want, model_f(ops[i], xs[i], ys[i]));
            else
                passed++;
            prev = want;
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x, y;
        real         ry;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(7, 0));
            if (o == 3'd3) begin
                ry = rnd_real();
                if (ry == 0.0)
                    ry = 3.0;
                y = r2f(ry);
                x = r2f(f2r(y) * real'(int'($urandom_range(100, 0)) - 50));
            end else begin
                x = r2f(rnd_real());
                y = (i % 7 == 0) ? x : r2f(rnd_real());
            end
            drive(o, x, y);
            total++;
            if (z !== model_z(o, x, y) || {gr, ls, eq} !== model_f(o, x, y))
                $display("FAIL rnd%0d op=%0d a=%h b=%h z=%h flags=%b exp z=%h flags=%b",
                         i, o, x, y, z, {gr, ls, eq}, model_z(o, x, y), model_f(o, x, y));
            else
                passed++;
        end
    endtask

    initial begin
        test_reset();
        test_addsub();
        test_mul();
        test_div();
        test_compare();
        test_specials();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
Single-cycle, registered IEEE-754 single-precision floating-point ALU. It performs add, subtract, multiply, divide and compare on two 32-bit operands, selected by a 3-bit opcode. Result and compare flags are registered on the rising clock edge. It sits as a standalone datapath slice driven directly by a controller or bench.

Parameters:
None. The format is fixed at binary32: 1 sign bit, 8 exponent bits (bias 127), 23 fraction bits.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- op  input  3  operation select
- a  input  32  operand A, binary32
- b  input  32  operand B, binary32
- z  output  32  registered result, binary32
- gr  output  1  registered flag, A > B
- ls  output  1  registered flag, A < B
- eq  output  1  registered flag, A == B

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: on a rising edge with rst=1, z=0x00000000 and gr=ls=eq=0. Reset has priority over op. A reset mid-stream discards the operation sampled on that edge.
- Latency: a, b and op are sampled each rising edge; outputs reflect them after that edge (1 cycle). No handshake. A new operation may be issued every cycle.
- Opcode map:
  - 000: z = a + b.
  - 001: z = a - b.
  - 010: z = a * b.
  - 011: z = a / b.
  - 100: compare. z=0; gr/ls/eq updated.
  - 101, 110, 111: NOP. z=0, flags=0.
- Flags are 0 for every op other than 100.
- Denormals: an input with exponent 0 is treated as signed zero (flush-to-zero). A result below the minimum normal flushes to +0.
- Overflow: exponent >= 255 yields signed infinity (exp=0xFF, frac=0).
- Special inputs:
  - Any NaN operand, inf-inf, 0*inf, 0/0 or inf/inf yields canonical NaN 0x7FC00000.
  - x/0 with x nonzero yields signed infinity.
  - x/inf yields signed zero.
  - Inf arithmetic otherwise follows IEEE sign rules.
- Add/sub datapath:
  - Subtract is add with b's sign inverted.
  - Order operands by magnitude and align the smaller significand right by the exponent difference, keeping 3 extra low bits (guard, round, sticky).
  - Add or subtract significands, then normalise (leading-one detect, left shift; or 1-bit right shift on carry).
  - An exact-zero result is +0.
- Multiply: sign = sa^sb; exp = ea+eb-127; 24x24 significand product, normalised.
- Divide: sign = sa^sb; exp = ea-eb+127; significand quotient of at least 26 bits (restoring division, combinational), normalised.
- Rounding: round toward zero (truncate) for all ops. Exactly representable results must be bit-exact.
- Compare:
  - +0 equals -0.
  - Ordinary ordering of signed values, including infinities.
  - If either operand is NaN: gr=ls=eq=0.
  - Exactly one flag is set for non-NaN operands.

Optional Feature:
FPALU_DIV_EN:
- Defined: op 011 performs division as above.
- Undefined: the divider is not built; op 011 behaves as a NOP (z=0, flags=0). All other ops are unchanged.

Test Plan:
- Reset: rst=1 for one edge with op=000, a=0x3F800000, b=0x3F800000 -> z=0x00000000, gr=ls=eq=0. Then op=110 (NOP) for several cycles -> z stays 0.
- Add/sub with mixed signs:
  - op=000, a=0x3F800000 (1.0), b=0xBF400000 (-0.75) -> next edge z=0x3E800000 (0.25).
  - op=001, a=0xBF800000 (-1.0), b=0xBF400000 (-0.75) -> z=0xBE800000 (-0.25).
- Multiply: op=010, a=0xC1200000 (-10), b=0x40000000 (2) -> z=0xC1A00000 (-20), flags 0.
- Divide (with FPALU_DIV_EN):
  - op=011, a=0x40C00000 (6), b=0x3FC00000 (1.5) -> z=0x40800000 (4).
  - a=0x3F800000, b=0x00000000 -> z=0x7F800000.
- Compare:
  - op=100, a=0x40200000 (2.5), b=0x3FC00000 (1.5) -> gr=1, ls=0, eq=0, z=0.
  - Swap a and b -> ls=1.
  - a=0x80000000, b=0x00000000 -> eq=1.
  - a=0x7FC00000 -> all flags 0.
- Specials and back-to-back:
  - op=000, a=0x7F800000, b=0xFF800000 -> z=0x7FC00000.
  - op=010, a=0x7F000000, b=0x7F000000 -> z=0x7F800000.
  - Change op every cycle -> each result appears exactly one edge after its inputs.
